// File: rtl/i2c_arb_pkg.sv
// Shared types and sizing constants for the two-requester I2C arbiter.
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      RESP
   } state_t;

   localparam int unsigned N_REQ               = 2;
   localparam int unsigned ADDR_W              = 7;
   localparam int unsigned DATA_W              = 8;
   localparam int unsigned DEF_TIMEOUT_CYCLES  = 200000;

endpackage

// File: rtl/i2c_watchdog.sv
// Cycle counter that flags expiry once TIMEOUT_CYCLES enabled cycles have elapsed since clear.
module i2c_watchdog
   import i2c_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   // Flag in the last counted cycle so the owner acts on the edge that ends it.
   assign expired = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between two requesters, with a watchdog abort.
module i2c_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_op,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_din,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]         rsp_dout,
   output logic                      rsp_ack_err,
   output logic                      rsp_timeout,
   output logic                      m_newd,
   output logic                      m_op,
   output logic [ADDR_W-1:0]         m_addr,
   output logic [DATA_W-1:0]         m_din,
   input  logic                      m_busy,
   input  logic                      m_done,
   input  logic                      m_ack_err,
   input  logic [DATA_W-1:0]         m_dout
);

   state_t            state_q;
   state_t            state_d;
   logic              last_srv;
   logic              win;
   logic              win_op;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_din;
   logic              wd_clr;
   logic              wd_en;
   logic              wd_expired;
   logic              unused_busy;

   assign unused_busy = m_busy;

   // Requester 1 wins when it is alone, or when both ask and 0 was served last.
   always_comb begin
      win      = req[1] & (~req[0] | ~last_srv);
      win_op   = win ? req_op[1] : req_op[0];
      win_addr = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      win_din  = win ? req_din[2*DATA_W-1:DATA_W] : req_din[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wd_clr  = 1'b1;
      wd_en   = 1'b0;
      case (state_q)
         IDLE:      if (|req) state_d = ISSUE;
         ISSUE:     state_d = WAIT_DONE;
         WAIT_DONE: begin
            wd_clr = 1'b0;
            wd_en  = 1'b1;
            if (m_done || wd_expired) state_d = RESP;
         end
         RESP:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt         <= '0;
         rsp_valid   <= '0;
         rsp_dout    <= '0;
         rsp_ack_err <= 1'b0;
         rsp_timeout <= 1'b0;
         m_newd      <= 1'b0;
         m_op        <= 1'b0;
         m_addr      <= '0;
         m_din       <= '0;
         last_srv    <= 1'b1;
      end else begin
         m_newd    <= (state_q == ISSUE);
         rsp_valid <= '0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  gnt      <= '0;
                  gnt[win] <= 1'b1;
                  m_op     <= win_op;
                  m_addr   <= win_addr;
                  m_din    <= win_din;
               end
            end
            WAIT_DONE: begin
               // A completion in the expiry cycle still reports real data.
               if (m_done) begin
                  rsp_valid   <= gnt;
                  rsp_dout    <= m_dout;
                  rsp_ack_err <= m_ack_err;
                  rsp_timeout <= 1'b0;
               end else if (wd_expired) begin
                  rsp_valid   <= gnt;
                  rsp_dout    <= '0;
                  rsp_ack_err <= 1'b0;
                  rsp_timeout <= 1'b1;
               end
            end
            RESP: begin
               gnt      <= '0;
               last_srv <= gnt[1];
            end
            default: ;
         endcase
      end
   end

   i2c_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed and randomized transactions against a round-robin reference model of the arbiter.
module tb_i2c_arbiter;

   localparam int TO = 50;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  req_op;
   logic [13:0] req_addr;
   logic [15:0] req_din;
   logic [1:0]  gnt;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_dout;
   logic        rsp_ack_err;
   logic        rsp_timeout;
   logic        m_newd;
   logic        m_op;
   logic [6:0]  m_addr;
   logic [7:0]  m_din;
   logic        m_busy;
   logic        m_done;
   logic        m_ack_err;
   logic [7:0]  m_dout;

   int total = 0;
   int bad   = 0;
   int last_srv;

   always #5 clk = ~clk;

   i2c_arbiter #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_op      (req_op),
      .req_addr    (req_addr),
      .req_din     (req_din),
      .gnt         (gnt),
      .rsp_valid   (rsp_valid),
      .rsp_dout    (rsp_dout),
      .rsp_ack_err (rsp_ack_err),
      .rsp_timeout (rsp_timeout),
      .m_newd      (m_newd),
      .m_op        (m_op),
      .m_addr      (m_addr),
      .m_din       (m_din),
      .m_busy      (m_busy),
      .m_done      (m_done),
      .m_ack_err   (m_ack_err),
      .m_dout      (m_dout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt"},       gnt, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_dout"},  rsp_dout, 0);
      chk({tag, "_ack_err"},   rsp_ack_err, 0);
      chk({tag, "_timeout"},   rsp_timeout, 0);
      chk({tag, "_m_newd"},    m_newd, 0);
      chk({tag, "_m_op"},      m_op, 0);
      chk({tag, "_m_addr"},    m_addr, 0);
      chk({tag, "_m_din"},     m_din, 0);
   endtask

   // delay < 0 means the master never completes (watchdog case).
   task automatic txn(input logic [1:0] mask, input logic [1:0] op, input logic [13:0] addr,
                      input logic [15:0] din, input int delay, input logic [7:0] rdata,
                      input logic nack, input bit drop);
      int         w;
      int         k;
      logic [1:0] oh;
      req_op   = op;
      req_addr = addr;
      req_din  = din;
      req      = mask;
      m_busy   = 1'($urandom);
      chk("idle_gnt", gnt, 0);
      w  = (mask == 2'b11) ? 1 - last_srv : (mask[0] ? 0 : 1);
      oh = 2'b01 << w;
      tick();
      chk("grant", gnt, oh);
      chk("newd_early", m_newd, 0);
      if (drop) req[w] = 1'b0;
      tick();
      chk("newd", m_newd, 1);
      chk("m_op", m_op, op[w]);
      chk("m_addr", m_addr, addr[w*7 +: 7]);
      chk("m_din", m_din, din[w*8 +: 8]);
      if (delay < 0) begin
         k = 0;
         for (int i = 1; i <= TO + 20; i++) begin
            tick();
            if (rsp_valid !== 2'b00) begin
               k = i;
               break;
            end
         end
         chk("timeout_latency", k, TO);
         chk("timeout_valid", rsp_valid, oh);
         chk("timeout_flag", rsp_timeout, 1);
         chk("timeout_dout", rsp_dout, 0);
      end else begin
         for (int i = 0; i < delay; i++) begin
            tick();
            chk("wait_no_rsp", rsp_valid, 0);
            chk("wait_newd_low", m_newd, 0);
         end
         m_done    = 1'b1;
         m_dout    = rdata;
         m_ack_err = nack;
         tick();
         m_done    = 1'b0;
         m_dout    = 8'($urandom);
         m_ack_err = 1'($urandom);
         chk("rsp_valid", rsp_valid, oh);
         chk("rsp_dout", rsp_dout, rdata);
         chk("rsp_ack_err", rsp_ack_err, nack);
         chk("rsp_timeout", rsp_timeout, 0);
         chk("rsp_gnt", gnt, oh);
      end
      req[w] = 1'b0;
      tick();
      chk("rsp_pulse_end", rsp_valid, 0);
      chk("gnt_clear", gnt, 0);
      last_srv = w;
   endtask

   initial begin
      rst       = 1'b0;
      req       = '0;
      req_op    = '0;
      req_addr  = '0;
      req_din   = '0;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_ack_err = 1'b0;
      m_dout    = '0;
      last_srv  = 1;
      repeat (3) tick();
      chk_reset_outputs("reset");
      rst = 1'b1;
      tick();

      // Round-robin from reset: 0, 1, 0, 1.
      txn(2'b11, 2'b00, 14'h1F2A, 16'h3355, 2, 8'h11, 1'b0, 1'b0);
      txn(2'b10, 2'b00, 14'h1F2A, 16'h3355, 1, 8'h22, 1'b0, 1'b0);
      txn(2'b11, 2'b01, 14'h0ABC, 16'h7788, 0, 8'h33, 1'b0, 1'b0);
      txn(2'b10, 2'b10, 14'h0ABC, 16'h7788, 3, 8'h44, 1'b0, 1'b0);

      // Single write to 0x50, then a read returning 0x3C, then a NACK.
      txn(2'b01, 2'b00, {7'h00, 7'h50}, {8'h00, 8'hA5}, 3, 8'h00, 1'b0, 1'b0);
      txn(2'b10, 2'b10, {7'h2D, 7'h00}, 16'h0000, 4, 8'h3C, 1'b0, 1'b0);
      txn(2'b01, 2'b00, {7'h00, 7'h21}, 16'h00F0, 2, 8'h00, 1'b1, 1'b0);

      // Completion outside WAIT_DONE must not produce a response.
      m_done = 1'b1;
      m_dout = 8'hFF;
      tick();
      m_done = 1'b0;
      chk("stray_done_valid", rsp_valid, 0);
      chk("stray_done_gnt", gnt, 0);
      tick();
      chk("stray_done_valid2", rsp_valid, 0);

      // Requester drops its line after grant; response still arrives.
      txn(2'b10, 2'b11, 14'h2345, 16'hBEEF, 2, 8'h5A, 1'b0, 1'b1);

      for (int n = 0; n < 30; n++) begin
         txn(2'($urandom_range(3, 1)), 2'($urandom), 14'($urandom), 16'($urandom),
             int'($urandom_range(6, 0)), 8'($urandom), 1'($urandom), 1'($urandom));
      end

      txn(2'b01, 2'b01, 14'h0013, 16'h0077, -1, 8'h00, 1'b0, 1'b0);
      txn(2'b11, 2'b00, 14'h1111, 16'h2222, 1, 8'h99, 1'b0, 1'b0);

      // Reset during WAIT_DONE: silent abort, pointer back to its reset value.
      req      = 2'b01;
      req_addr = 14'h0042;
      req_din  = 16'h00C3;
      repeat (4) tick();
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      req = '0;
      repeat (2) begin
         tick();
         chk("midreset_no_rsp", rsp_valid, 0);
      end
      rst      = 1'b1;
      last_srv = 1;
      tick();
      chk("post_reset_gnt", gnt, 0);
      txn(2'b01, 2'b00, 14'h0050, 16'h00A5, 2, 8'h0F, 1'b0, 1'b0);
      txn(2'b11, 2'b00, 14'h1234, 16'h5678, 1, 8'h1E, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
